// File: rtl/gs_band_pkg.sv
// Shared constants, FSM state type and the exact floor-by-20 helper for the
// banded Gauss-Seidel solver.
package gs_band_pkg;

  // Band coefficients of the row equation (magnitudes; signs are applied in the row update)
  localparam int DIAG = 20;
  localparam int C1   = 13;
  localparam int C2   = 6;
  localparam int C3   = 1;

  // Accumulator headroom over XW: SW = XW + SW_EXTRA cannot overflow for any x
  localparam int SW_EXTRA = 6;

  // Working width of the divider; wide enough for any practical SW
  localparam int DIV_W = 128;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SOLVE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // floor(s / 20): the native signed divide truncates toward zero, so a
  // negative dividend with a non-zero remainder is stepped down by one.
  function automatic logic signed [DIV_W-1:0] floor_div20(input logic signed [DIV_W-1:0] s);
    logic signed [DIV_W-1:0] q;
    q = s / DIV_W'(DIAG);
    if (s[DIV_W-1] && ((q * DIV_W'(DIAG)) != s)) q = q - DIV_W'(1);
    return q;
  endfunction

endpackage

// File: rtl/gs_band_solver_if.sv
// Handshake bundle between the b-vector source, the solver and the x consumer.
interface gs_band_solver_if #(
  parameter int BW = 16,
  parameter int XW = 32,
  parameter int IW = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] b_in;
  logic                 conv_en;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [XW-1:0] x_out;
  logic [IW-1:0]        x_idx;
  logic                 x_last;
  logic [7:0]           sweeps;
  logic                 converged;
  logic                 busy;

  modport master (
    output in_valid, b_in, conv_en, out_ready,
    input  in_ready, out_valid, x_out, x_idx, x_last, sweeps, converged, busy
  );

  modport slave (
    input  in_valid, b_in, conv_en, out_ready,
    output in_ready, out_valid, x_out, x_idx, x_last, sweeps, converged, busy
  );
endinterface

// File: rtl/gs_row_update.sv
// Combinational single-row Gauss-Seidel update: new x_i from b_i and the six
// band neighbours, plus the magnitude of the step for convergence tracking.
module gs_row_update
  import gs_band_pkg::*;
#(
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16
) (
  input  logic signed [BW-1:0] b_i,
  input  logic signed [XW-1:0] x_old,
  input  logic signed [XW-1:0] x_m1,
  input  logic signed [XW-1:0] x_p1,
  input  logic signed [XW-1:0] x_m2,
  input  logic signed [XW-1:0] x_p2,
  input  logic signed [XW-1:0] x_m3,
  input  logic signed [XW-1:0] x_p3,
  output logic signed [XW-1:0] x_new,
  output logic        [XW:0]   abs_delta
);
  localparam int SW = XW + SW_EXTRA;
  localparam int DW = XW + 1;

  logic signed [XW-1:0] b_fx;
  logic signed [SW-1:0] acc;
  logic signed [DW-1:0] delta;

  // Accumulate the row at full width, floor-divide by the diagonal, measure the step
  always_comb begin
    b_fx  = XW'(b_i) <<< FRAC;
    acc   = SW'(b_fx)
          + SW'(C1) * (SW'(x_m1) + SW'(x_p1))
          - SW'(C2) * (SW'(x_m2) + SW'(x_p2))
          + SW'(C3) * (SW'(x_m3) + SW'(x_p3));
    x_new = XW'(floor_div20(DIV_W'(acc)));
    delta = DW'(x_new) - DW'(x_old);
    abs_delta = delta[DW-1] ? unsigned'(-delta) : unsigned'(delta);
  end

endmodule

// File: rtl/gs_band_solver.sv
// Banded Gauss-Seidel solver: loads b, sweeps rows one per clock until the
// sweep limit or early convergence, then streams x out with backpressure.
module gs_band_solver
  import gs_band_pkg::*;
#(
  parameter int N    = 16,
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16,
  parameter int ITER = 50,
  parameter int EPS  = 16
) (
  input  logic              clk,
  input  logic              rst_in,
  gs_band_solver_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = XW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        ld_idx_q, ld_idx_d;
  logic [IW-1:0]        row_q, row_d;
  logic [IW-1:0]        out_idx_q, out_idx_d;
  logic [7:0]           sweeps_q, sweeps_d;
  logic                 conv_q, conv_d;
  logic                 conv_en_q, conv_en_d;
  logic [DW-1:0]        dmax_q, dmax_d;

  logic signed [BW-1:0] b_q [N];
  logic signed [XW-1:0] x_q [N];

  logic                 load_fire;
  logic                 solve_we;
  logic [DW-1:0]        dmax_sweep;
  logic [7:0]           sweeps_inc;

  logic signed [XW-1:0] x_m1, x_p1, x_m2, x_p2, x_m3, x_p3;
  logic signed [XW-1:0] x_new;
  logic [DW-1:0]        abs_delta;

  // Out-of-range neighbours read as zero
  function automatic logic signed [XW-1:0] nbr(input int j);
    logic [IW-1:0] jj;
    jj = j[IW-1:0];
    if (j < 0 || j >= N) return '0;
    return x_q[jj];
  endfunction

  // Gather the band around the current row; row-1 already holds this sweep's value
  always_comb begin
    x_m1 = nbr(int'(row_q) - 1);
    x_p1 = nbr(int'(row_q) + 1);
    x_m2 = nbr(int'(row_q) - 2);
    x_p2 = nbr(int'(row_q) + 2);
    x_m3 = nbr(int'(row_q) - 3);
    x_p3 = nbr(int'(row_q) + 3);
  end

  gs_row_update #(
    .BW   (BW),
    .XW   (XW),
    .FRAC (FRAC)
  ) u_row (
    .b_i       (b_q[row_q]),
    .x_old     (x_q[row_q]),
    .x_m1      (x_m1),
    .x_p1      (x_p1),
    .x_m2      (x_m2),
    .x_p2      (x_p2),
    .x_m3      (x_m3),
    .x_p3      (x_p3),
    .x_new     (x_new),
    .abs_delta (abs_delta)
  );

  // Next-state and counter logic for LOAD -> SOLVE -> DRAIN
  always_comb begin
    state_d    = state_q;
    ld_idx_d   = ld_idx_q;
    row_d      = row_q;
    out_idx_d  = out_idx_q;
    sweeps_d   = sweeps_q;
    conv_d     = conv_q;
    conv_en_d  = conv_en_q;
    dmax_d     = dmax_q;
    load_fire  = 1'b0;
    solve_we   = 1'b0;
    dmax_sweep = dmax_q;
    sweeps_inc = sweeps_q + 8'd1;
    unique case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_fire = 1'b1;
          if (ld_idx_q == '0) begin
            conv_en_d = bus.conv_en;
            sweeps_d  = '0;
            conv_d    = 1'b0;
          end
          if (ld_idx_q == IDX_LAST) begin
            ld_idx_d = '0;
            row_d    = '0;
            dmax_d   = '0;
            state_d  = ST_SOLVE;
          end else begin
            ld_idx_d = ld_idx_q + IW'(1);
          end
        end
      end
      ST_SOLVE: begin
        solve_we   = 1'b1;
        dmax_sweep = ((row_q == '0) || (abs_delta > dmax_q)) ? abs_delta : dmax_q;
        dmax_d     = dmax_sweep;
        if (row_q == IDX_LAST) begin
          row_d    = '0;
          sweeps_d = sweeps_inc;
          if (conv_en_q && (dmax_sweep < DW'(EPS)) && (sweeps_inc >= 8'd2)) begin
            conv_d    = 1'b1;
            out_idx_d = '0;
            state_d   = ST_DRAIN;
          end else if (sweeps_inc == 8'(ITER)) begin
            conv_d    = 1'b0;
            out_idx_d = '0;
            state_d   = ST_DRAIN;
          end
        end else begin
          row_d = row_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (out_idx_q == IDX_LAST) begin
            out_idx_d = '0;
            state_d   = ST_LOAD;
          end else begin
            out_idx_d = out_idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_LOAD;
      ld_idx_q  <= '0;
      row_q     <= '0;
      out_idx_q <= '0;
      sweeps_q  <= '0;
      conv_q    <= 1'b0;
      conv_en_q <= 1'b0;
      dmax_q    <= '0;
    end else begin
      state_q   <= state_d;
      ld_idx_q  <= ld_idx_d;
      row_q     <= row_d;
      out_idx_q <= out_idx_d;
      sweeps_q  <= sweeps_d;
      conv_q    <= conv_d;
      conv_en_q <= conv_en_d;
      dmax_q    <= dmax_d;
    end
  end

  // b/x storage: loading clears x[i], each SOLVE cycle writes back the updated row
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < N; k++) begin
        b_q[k] <= '0;
        x_q[k] <= '0;
      end
    end else begin
      if (load_fire) begin
        b_q[ld_idx_q] <= bus.b_in;
        x_q[ld_idx_q] <= '0;
      end
      if (solve_we) x_q[row_q] <= x_new;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.x_out     = (state_q == ST_DRAIN) ? x_q[out_idx_q] : '0;
  assign bus.x_idx     = out_idx_q;
  assign bus.x_last    = (state_q == ST_DRAIN) && (out_idx_q == IDX_LAST);
  assign bus.sweeps    = sweeps_q;
  assign bus.converged = conv_q;
  assign bus.busy      = (state_q != ST_LOAD);

endmodule
